hist_eq_lut_ctrl: RTL and testbench
===================================

Name: hist_eq_lut_ctrl

Overview:
- Consumes the per-level cumulative histogram stream (level, cumulative count, valid) produced by the histogram statistics block at frame end.
- Scales each cumulative count to an 8-bit equalisation mapping and writes it into the shadow bank of an internal ping-pong 2x256x8 LUT.
- Swaps banks at the next frame start and serves a 1-cycle pixel lookup port to the downstream pixel path.
- Sequences table build, integrity checking and bank ownership so the pixel path never reads a partially written table.

Parameters:
- ACC_W, 20, width of cumulative count input.
- RECIP, 13926, round(255 * 2^SHIFT / total pixels); default is for 640x480.
- RECIP_W, 16, width of RECIP.
- SHIFT, 24, right shift applied after the multiply.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- img_vsync  in  1  frame sync; a rising edge marks frame start
- cdf_level  in  8  gray level of the current CDF entry
- cdf_acc_num  in  ACC_W  cumulative pixel count up to and including cdf_level
- cdf_valid  in  1  CDF entry qualifier
- pix_in_valid  in  1  lookup request
- pix_in  in  8  gray value to map
- pix_out_valid  out  1  lookup result valid
- pix_out  out  8  mapped gray value
- active_bank  out  1  bank currently read by the lookup port
- table_valid  out  1  at least one complete table has been swapped in
- seq_err  out  1  one-cycle pulse on a CDF sequence error

Behaviour:
- Reset (asynchronous, active-high) clears all outputs, active_bank, state and the pipeline to 0. FSM goes to IDLE. LUT contents are not cleared, because table_valid=0 gates their use.
- Pipeline, 3 stages (registered input -> product -> round/saturate/write). A CDF entry accepted in cycle t is written into the shadow bank (~active_bank) at the end of cycle t+3.
- Arithmetic:
  - prod = cdf_acc_num * RECIP, unsigned, ACC_W+RECIP_W bits.
  - map = (prod + 2^(SHIFT-1)) >> SHIFT.
  - If map > 255, saturate to 255.
- expect_lvl: 9-bit counter, 0..256.
- FSM states:
  - IDLE: cdf_valid with cdf_level==0 -> FILL, expect_lvl=1, entry accepted. cdf_valid with level!=0 -> ERR, seq_err pulse, entry dropped.
  - FILL:
    - cdf_valid with level==expect_lvl[7:0] -> accept, expect_lvl++.
    - Acceptance of level 255 -> DRAIN.
    - cdf_valid with a mismatched level -> ERR, seq_err pulse, entry dropped.
    - cdf_valid low for a cycle -> stay in FILL; gaps are allowed.
    - img_vsync rising while in FILL -> ERR, seq_err pulse (incomplete table).
  - DRAIN: waits 3 cycles for the pipeline to empty -> READY.
  - READY: img_vsync rising -> active_bank toggles, table_valid<=1, -> IDLE. cdf_valid in READY -> ERR, seq_err pulse; no swap happens and the shadow bank is discarded.
  - ERR: waits until cdf_valid has been low for 1 cycle -> IDLE. Entries received while in ERR are ignored; no further seq_err pulses are generated.
- Bank ownership:
  - The shadow bank is written only while in FILL or DRAIN.
  - active_bank changes only on a vsync rising edge observed in READY.
  - A vsync edge in any other state leaves active_bank unchanged, so the old table is kept.
- Vsync edge detection uses a 1-cycle registered img_vsync. The swap takes effect in the cycle after the edge is detected.
- Lookup port: pix_out_valid <= pix_in_valid (latency 1).
  - table_valid=1: pix_out <= LUT[active_bank][pix_in].
  - table_valid=0: pix_out <= pix_in (pass-through).
  - If a lookup and a swap fall in the same cycle, the lookup reads the pre-swap bank.
- Lookup reads and shadow writes never target the same bank. No read/write collision is possible.
- Reset mid-FILL: the partial table is abandoned, table_valid returns to 0 and the port passes pixels through.

Test Plan:
- Clean build: stream levels 0..255 with cdf_acc_num = 1200*(L+1), then a vsync rise -> active_bank 0->1, table_valid=1. Lookup pix_in=0 gives 1; pix_in=127 gives 127; pix_in=255 gives 255 (acc 307200). All with pix_out_valid exactly 1 cycle after pix_in_valid.
- Arithmetic: acc=0 -> 0. acc=153600 -> 127. acc=1048575 -> saturates to 255.
- Out-of-order: level sequence 0,1,2,4 -> seq_err single pulse at level 4. The following vsync rise leaves active_bank unchanged. A restart at level 0 then builds a full table, which swaps on the next vsync.
- Incomplete frame: only levels 0..99, then a vsync rise -> seq_err pulse, no swap. Lookups still return the previous table (or pass-through if table_valid=0).
- Gapped stream: cdf_valid deasserted for 5 cycles between every entry -> table is identical to the clean-build case and no seq_err occurs.
- Reset: assert rst in FILL after level 50 -> all outputs 0 immediately. After release, lookup pix_in=77 returns 77 (pass-through).

Source files
------------

// File: rtl/hist_eq_lut_ctrl.sv
// Histogram-equalisation LUT controller: scales the CDF stream into a shadow
// bank of a ping-pong 2x256x8 table and swaps it in at the next frame start.
module hist_eq_lut_ctrl #(
  parameter int ACC_W   = 20,
  parameter int RECIP   = 13926,
  parameter int RECIP_W = 16,
  parameter int SHIFT   = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             img_vsync,
  input  logic [7:0]       cdf_level,
  input  logic [ACC_W-1:0] cdf_acc_num,
  input  logic             cdf_valid,
  input  logic             pix_in_valid,
  input  logic [7:0]       pix_in,
  output logic             pix_out_valid,
  output logic [7:0]       pix_out,
  output logic             active_bank,
  output logic             table_valid,
  output logic             seq_err
);

  localparam int PROD_W = ACC_W + RECIP_W;
  localparam logic [RECIP_W-1:0] RECIP_C = RECIP_W'(RECIP);
  localparam logic [PROD_W:0]    HALF    = (PROD_W+1)'(1) << (SHIFT-1);

  typedef enum logic [2:0] {IDLE, FILL, DRAIN, READY, ERR} state_t;

  state_t      state, state_nx;
  logic [8:0]  expect_lvl, expect_lvl_nx;
  logic [1:0]  drain_cnt, drain_cnt_nx;
  logic        accept, err_now, swap;
  logic        vsync_d, vsync_rise;

  logic               s1_valid, s2_valid, s3_valid;
  logic [7:0]         s1_level, s2_level, s3_level;
  logic [ACC_W-1:0]   s1_acc;
  logic [PROD_W-1:0]  s2_prod;
  logic [7:0]         s3_map;
  logic [PROD_W:0]    rnd_sum, map_wide;
  logic [7:0]         map_sat;
  logic               shadow_we;

  logic [7:0] lut [512];

  assign vsync_rise = img_vsync & ~vsync_d;

  always_comb begin
    state_nx      = state;
    expect_lvl_nx = expect_lvl;
    drain_cnt_nx  = drain_cnt;
    accept        = 1'b0;
    err_now       = 1'b0;
    swap          = 1'b0;
    case (state)
      IDLE: begin
        if (cdf_valid) begin
          if (cdf_level == 8'd0) begin
            accept        = 1'b1;
            expect_lvl_nx = 9'd1;
            state_nx      = FILL;
          end else begin
            err_now  = 1'b1;
            state_nx = ERR;
          end
        end
      end
      FILL: begin
        // A frame start before level 255 means the table can never complete.
        if (vsync_rise) begin
          err_now  = 1'b1;
          state_nx = ERR;
        end else if (cdf_valid) begin
          if ({1'b0, cdf_level} == expect_lvl) begin
            accept        = 1'b1;
            expect_lvl_nx = expect_lvl + 9'd1;
            if (cdf_level == 8'hFF) begin
              state_nx     = DRAIN;
              drain_cnt_nx = 2'd0;
            end
          end else begin
            err_now  = 1'b1;
            state_nx = ERR;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt == 2'd2) state_nx = READY;
        else                   drain_cnt_nx = drain_cnt + 2'd1;
      end
      READY: begin
        if (cdf_valid) begin
          err_now  = 1'b1;
          state_nx = ERR;
        end else if (vsync_rise) begin
          swap     = 1'b1;
          state_nx = IDLE;
        end
      end
      ERR: begin
        if (!cdf_valid) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      expect_lvl  <= '0;
      drain_cnt   <= '0;
      vsync_d     <= 1'b0;
      seq_err     <= 1'b0;
      active_bank <= 1'b0;
      table_valid <= 1'b0;
    end else begin
      state      <= state_nx;
      expect_lvl <= expect_lvl_nx;
      drain_cnt  <= drain_cnt_nx;
      vsync_d    <= img_vsync;
      seq_err    <= err_now;
      if (swap) begin
        active_bank <= ~active_bank;
        table_valid <= 1'b1;
      end
    end
  end

  // Round-half-up after the reciprocal multiply, then clamp to 8 bits.
  assign rnd_sum  = {1'b0, s2_prod} + HALF;
  assign map_wide = rnd_sum >> SHIFT;
  assign map_sat  = (|map_wide[PROD_W:8]) ? 8'hFF : map_wide[7:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_level <= '0;
      s1_acc   <= '0;
      s2_valid <= 1'b0;
      s2_level <= '0;
      s2_prod  <= '0;
      s3_valid <= 1'b0;
      s3_level <= '0;
      s3_map   <= '0;
    end else begin
      s1_valid <= accept;
      s1_level <= cdf_level;
      s1_acc   <= cdf_acc_num;
      s2_valid <= s1_valid;
      s2_level <= s1_level;
      s2_prod  <= PROD_W'(s1_acc) * PROD_W'(RECIP_C);
      s3_valid <= s2_valid;
      s3_level <= s2_level;
      s3_map   <= map_sat;
    end
  end

  // Late writes from an aborted build are dropped; the shadow is discarded anyway.
  assign shadow_we = s3_valid && ((state == FILL) || (state == DRAIN));

  always_ff @(posedge clk) begin
    if (shadow_we) lut[{~active_bank, s3_level}] <= s3_map;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_out_valid <= 1'b0;
      pix_out       <= '0;
    end else begin
      pix_out_valid <= pix_in_valid;
      pix_out       <= table_valid ? lut[{active_bank, pix_in}] : pix_in;
    end
  end

endmodule

// File: tb/tb_hist_eq_lut_ctrl.sv
// Randomized self-checking bench for hist_eq_lut_ctrl against a frame-level
// reference model of table building, error handling and bank swapping.
module tb_hist_eq_lut_ctrl;

  localparam int ACC_W = 20;
  localparam longint unsigned RECIP_L = 64'd13926;
  localparam int SHIFT = 24;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             img_vsync = 1'b0;
  logic [7:0]       cdf_level = '0;
  logic [ACC_W-1:0] cdf_acc_num = '0;
  logic             cdf_valid = 1'b0;
  logic             pix_in_valid = 1'b0;
  logic [7:0]       pix_in = '0;
  logic             pix_out_valid;
  logic [7:0]       pix_out;
  logic             active_bank;
  logic             table_valid;
  logic             seq_err;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;

  logic       vs_lvl = 1'b0;
  logic       force_pix = 1'b0;
  logic [7:0] force_val = '0;
  logic [ACC_W-1:0] acc_tab [256];

  // Reference model state: the expected outputs after each rising clock edge.
  logic       exp_pov = 1'b0;
  logic [7:0] exp_pix = '0;
  logic       exp_bank = 1'b0;
  logic       exp_tv = 1'b0;
  logic       exp_seq_err = 1'b0;
  int         m_act  [256];
  int         m_pend [256];
  bit         m_building = 0;
  bit         m_ready = 0;
  bit         m_err_hold = 0;
  int         m_next = 0;
  int         m_drain = 0;
  logic       m_prev_vs = 1'b0;

  hist_eq_lut_ctrl #(
    .ACC_W(20), .RECIP(13926), .RECIP_W(16), .SHIFT(24)
  ) dut (
    .clk(clk), .rst(rst), .img_vsync(img_vsync),
    .cdf_level(cdf_level), .cdf_acc_num(cdf_acc_num), .cdf_valid(cdf_valid),
    .pix_in_valid(pix_in_valid), .pix_in(pix_in),
    .pix_out_valid(pix_out_valid), .pix_out(pix_out),
    .active_bank(active_bank), .table_valid(table_valid), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  // Plain-arithmetic equalisation mapping: round(acc * RECIP / 2^SHIFT), clamp 255.
  function automatic int mapOf(input logic [ACC_W-1:0] acc);
    longint unsigned p;
    p = 64'(acc) * RECIP_L;
    p = (p + (64'd1 << (SHIFT-1))) >> SHIFT;
    return (p > 64'd255) ? 255 : int'(p);
  endfunction

  // Frame-level protocol model: a table is usable only after all 256 levels
  // arrived in order, the pipeline drained, and a frame start was seen.
  always @(posedge clk or posedge rst) begin : model
    bit rise, err, swap;
    if (rst) begin
      exp_pov = 1'b0; exp_pix = '0; exp_bank = 1'b0; exp_tv = 1'b0; exp_seq_err = 1'b0;
      m_building = 0; m_ready = 0; m_err_hold = 0; m_next = 0; m_drain = 0;
      m_prev_vs = 1'b0;
    end else begin
      rise = img_vsync && !m_prev_vs;
      m_prev_vs = img_vsync;
      err = 0;
      swap = 0;
      exp_pov = pix_in_valid;
      exp_pix = exp_tv ? 8'(m_act[pix_in]) : pix_in;
      if (m_err_hold) begin
        if (!cdf_valid) m_err_hold = 0;
      end else if (m_ready) begin
        if (cdf_valid) begin
          err = 1; m_ready = 0; m_err_hold = 1;
        end else if (rise) begin
          swap = 1; m_ready = 0;
        end
      end else if (m_drain > 0) begin
        m_drain--;
        if (m_drain == 0) m_ready = 1;
      end else if (m_building) begin
        if (rise) begin
          err = 1; m_building = 0; m_err_hold = 1;
        end else if (cdf_valid) begin
          if (int'(cdf_level) == m_next) begin
            m_pend[cdf_level] = mapOf(cdf_acc_num);
            if (cdf_level == 8'd255) begin
              m_building = 0; m_drain = 3;
            end else m_next++;
          end else begin
            err = 1; m_building = 0; m_err_hold = 1;
          end
        end
      end else if (cdf_valid) begin
        if (cdf_level == 8'd0) begin
          m_pend[0] = mapOf(cdf_acc_num); m_building = 1; m_next = 1;
        end else begin
          err = 1; m_err_hold = 1;
        end
      end
      if (swap) begin
        m_act = m_pend;
        exp_bank = ~exp_bank;
        exp_tv = 1'b1;
      end
      exp_seq_err = err;
    end
  end

  // One comparison against its required value; prints a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // One clock cycle: drive inputs after the edge, compare outputs at the falling edge.
  task automatic applyStimulus(input logic v, input logic [7:0] lvl, input logic [ACC_W-1:0] acc);
    @(posedge clk);
    #1;
    cdf_valid = v;
    cdf_level = lvl;
    cdf_acc_num = acc;
    img_vsync = vs_lvl;
    if (force_pix) begin
      pix_in_valid = 1'b1;
      pix_in = force_val;
    end else begin
      pix_in_valid = 1'($urandom_range(0, 1));
      pix_in = 8'($urandom);
    end
    @(negedge clk);
    checkOutput("pix_out_valid", 32'(pix_out_valid), 32'(exp_pov));
    if (exp_pov) checkOutput("pix_out", 32'(pix_out), 32'(exp_pix));
    checkOutput("active_bank", 32'(active_bank), 32'(exp_bank));
    checkOutput("table_valid", 32'(table_valid), 32'(exp_tv));
    checkOutput("seq_err", 32'(seq_err), 32'(exp_seq_err));
    if (seq_err === 1'b1) err_pulses++;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 8'd0, '0);
  endtask

  task automatic pulseVsync();
    vs_lvl = 1'b1;
    idle(3);
    vs_lvl = 1'b0;
    idle(3);
  endtask

  // mode 0: the clean 640x480 ramp; mode 1: random non-decreasing counts.
  task automatic genAcc(input int mode);
    int unsigned s;
    s = 0;
    for (int l = 0; l < 256; l++) begin
      if (mode == 0) acc_tab[l] = ACC_W'(1200 * (l + 1));
      else begin
        s += $urandom_range(0, 2600);
        if (s > 1048575) s = 1048575;
        acc_tab[l] = ACC_W'(s);
      end
    end
  endtask

  task automatic sendLevels(input int first, input int last, input int gmin, input int gmax, input int skip);
    for (int l = first; l <= last; l++) begin
      if (l != skip) begin
        applyStimulus(1'b1, 8'(l), acc_tab[l]);
        idle(int'($urandom_range(gmax, gmin)));
      end
    end
  endtask

  task automatic lookupCheck(input logic [7:0] p, input logic [7:0] expv, input string name);
    force_pix = 1'b1;
    force_val = p;
    applyStimulus(1'b0, 8'd0, '0);
    force_pix = 1'b0;
    applyStimulus(1'b0, 8'd0, '0);
    checkOutput(name, 32'(pix_out), 32'(expv));
    checkOutput({name, "_valid"}, 32'(pix_out_valid), 32'd1);
  endtask

  task automatic sweepLookups();
    force_pix = 1'b1;
    for (int p = 0; p < 256; p++) begin
      force_val = 8'(p);
      applyStimulus(1'b0, 8'd0, '0);
    end
    force_pix = 1'b0;
    idle(1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog timeout at %0t", $time);
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin : main
    int e0, typ, k;

    // Reset state
    idle(3);
    checkOutput("rst_pix_out_valid", 32'(pix_out_valid), 32'd0);
    checkOutput("rst_pix_out", 32'(pix_out), 32'd0);
    checkOutput("rst_active_bank", 32'(active_bank), 32'd0);
    checkOutput("rst_table_valid", 32'(table_valid), 32'd0);
    checkOutput("rst_seq_err", 32'(seq_err), 32'd0);
    rst = 1'b0;
    idle(2);
    lookupCheck(8'd77, 8'd77, "passthru_77");

    // Hand-computed pins of the mapping model
    checkOutput("model_acc_0", 32'(mapOf(20'd0)), 32'd0);
    checkOutput("model_acc_153600", 32'(mapOf(20'd153600)), 32'd127);
    checkOutput("model_acc_max", 32'(mapOf(20'd1048575)), 32'd255);
    checkOutput("model_acc_1200", 32'(mapOf(20'd1200)), 32'd1);

    $display("[TB] clean build");
    genAcc(0);
    sendLevels(0, 255, 0, 0, -1);
    idle(6);
    checkOutput("clean_bank_before", 32'(active_bank), 32'd0);
    checkOutput("clean_tv_before", 32'(table_valid), 32'd0);
    pulseVsync();
    checkOutput("clean_bank_after", 32'(active_bank), 32'd1);
    checkOutput("clean_tv_after", 32'(table_valid), 32'd1);
    lookupCheck(8'd0, 8'd1, "clean_lut_0");
    lookupCheck(8'd127, 8'd127, "clean_lut_127");
    lookupCheck(8'd255, 8'd255, "clean_lut_255");

    $display("[TB] arithmetic corners");
    genAcc(1);
    acc_tab[0] = 20'd0;
    acc_tab[1] = 20'd153600;
    acc_tab[2] = 20'd1048575;
    sendLevels(0, 255, 0, 1, -1);
    idle(6);
    pulseVsync();
    checkOutput("arith_bank", 32'(active_bank), 32'd0);
    lookupCheck(8'd0, 8'd0, "arith_acc_0");
    lookupCheck(8'd1, 8'd127, "arith_acc_153600");
    lookupCheck(8'd2, 8'd255, "arith_acc_saturate");

    $display("[TB] out-of-order levels");
    e0 = err_pulses;
    genAcc(0);
    sendLevels(0, 4, 0, 0, 3);
    idle(4);
    checkOutput("ooo_err_pulses", 32'(err_pulses - e0), 32'd1);
    pulseVsync();
    checkOutput("ooo_bank_kept", 32'(active_bank), 32'd0);
    sendLevels(0, 255, 0, 1, -1);
    idle(6);
    pulseVsync();
    checkOutput("ooo_restart_bank", 32'(active_bank), 32'd1);
    lookupCheck(8'd127, 8'd127, "ooo_restart_lut_127");

    $display("[TB] incomplete frame");
    e0 = err_pulses;
    genAcc(1);
    sendLevels(0, 99, 0, 0, -1);
    pulseVsync();
    checkOutput("incomplete_err_pulses", 32'(err_pulses - e0), 32'd1);
    checkOutput("incomplete_bank_kept", 32'(active_bank), 32'd1);
    lookupCheck(8'd127, 8'd127, "incomplete_old_lut_127");

    $display("[TB] gapped stream");
    e0 = err_pulses;
    genAcc(0);
    sendLevels(0, 255, 5, 5, -1);
    idle(6);
    pulseVsync();
    checkOutput("gapped_err_pulses", 32'(err_pulses - e0), 32'd0);
    checkOutput("gapped_bank", 32'(active_bank), 32'd0);
    lookupCheck(8'd0, 8'd1, "gapped_lut_0");
    lookupCheck(8'd255, 8'd255, "gapped_lut_255");
    sweepLookups();

    $display("[TB] entry while ready");
    e0 = err_pulses;
    genAcc(1);
    sendLevels(0, 255, 0, 1, -1);
    idle(6);
    applyStimulus(1'b1, 8'($urandom), 20'd5);
    idle(3);
    pulseVsync();
    checkOutput("ready_err_pulses", 32'(err_pulses - e0), 32'd1);
    checkOutput("ready_bank_kept", 32'(active_bank), 32'd0);

    $display("[TB] random frames");
    for (int f = 0; f < 16; f++) begin
      e0 = err_pulses;
      typ = int'($urandom_range(0, 3));
      genAcc(1);
      case (typ)
        0: begin sendLevels(0, 255, 0, 2, -1); idle(6); end
        1: begin k = int'($urandom_range(1, 254)); sendLevels(0, k + 1, 0, 2, k); idle(4); end
        2: begin k = int'($urandom_range(0, 254)); sendLevels(0, k, 0, 2, -1); end
        default: begin
          sendLevels(0, 255, 0, 2, -1);
          idle(6);
          applyStimulus(1'b1, 8'($urandom), acc_tab[0]);
          idle(3);
        end
      endcase
      pulseVsync();
      checkOutput("rand_err_pulses", 32'(err_pulses - e0), (typ == 0) ? 32'd0 : 32'd1);
      sweepLookups();
    end

    $display("[TB] reset mid-fill");
    genAcc(0);
    sendLevels(0, 255, 0, 0, -1);
    idle(6);
    pulseVsync();
    sendLevels(0, 50, 0, 0, -1);
    idle(1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_pix_out_valid", 32'(pix_out_valid), 32'd0);
    checkOutput("midrst_pix_out", 32'(pix_out), 32'd0);
    checkOutput("midrst_active_bank", 32'(active_bank), 32'd0);
    checkOutput("midrst_table_valid", 32'(table_valid), 32'd0);
    checkOutput("midrst_seq_err", 32'(seq_err), 32'd0);
    idle(2);
    rst = 1'b0;
    idle(2);
    lookupCheck(8'd77, 8'd77, "midrst_passthru_77");
    checkOutput("midrst_tv_after", 32'(table_valid), 32'd0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
